// File: rtl/bus_interface_ws_pkg.sv
// Shared definitions for the parametrised CPU/debug bus interface.
//   - BUS_SEQX_* : bus sequence codes driven by the CPU sequencer
//   - bus_state_t: transaction state encoding
//   - helpers that classify a sequence code
package bus_interface_ws_pkg;

   localparam logic [2:0] BUS_SEQX_IDLE   = 3'd0;
   localparam logic [2:0] BUS_SEQX_IFETCH = 3'd1;
   localparam logic [2:0] BUS_SEQX_ARGRD  = 3'd2;
   localparam logic [2:0] BUS_SEQX_ARGWR  = 3'd3;
   localparam logic [2:0] BUS_SEQX_DFETCH = 3'd5;
   localparam logic [2:0] BUS_SEQX_DARGRD = 3'd6;
   localparam logic [2:0] BUS_SEQX_DARGWR = 3'd7;
   localparam int         BUS_SEQX_DEBUG_BIT = 2;

   typedef enum logic [1:0] {
      BUS_ST_IDLE   = 2'd0,
      BUS_ST_SETUP  = 2'd1,
      BUS_ST_STROBE = 2'd2,
      BUS_ST_HOLD   = 2'd3
   } bus_state_t;

   // Fetch codes (1 and 5) differ only in the debug bit.
   function automatic logic seq_is_fetch(input logic [2:0] seq);
      return seq[1:0] == BUS_SEQX_IFETCH[1:0];
   endfunction

   // Argument codes (2,3,6,7) all have bit 1 set; code 4 falls through to idle.
   function automatic logic seq_is_arg(input logic [2:0] seq);
      return seq[1];
   endfunction

   function automatic logic seq_is_write(input logic [2:0] seq);
      return seq[1:0] == BUS_SEQX_ARGWR[1:0];
   endfunction

endpackage

// File: rtl/bus_lane_steer.sv
// Byte-lane steering for the external bus (purely combinational).
//   byte_access : 1 = single byte, 0 = full word
//   lane        : byte lane index taken from the low address bits
//   wdata       : latched write data      -> wdata_out (byte replicated on all lanes)
//   rdata       : bus read data           -> rdata_out (selected lane zero-extended)
//   lane_en     : per-lane write enables
module bus_lane_steer #(
   parameter int DW = 16,
   localparam int LANES = DW / 8,
   localparam int LW = (LANES > 1) ? $clog2(LANES) : 1
)(
   input  logic             byte_access,
   input  logic [LW-1:0]    lane,
   input  logic [DW-1:0]    wdata,
   input  logic [DW-1:0]    rdata,
   output logic [LANES-1:0] lane_en,
   output logic [DW-1:0]    wdata_out,
   output logic [DW-1:0]    rdata_out
);

   logic [7:0] lane_bytes [LANES];

   for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign lane_bytes[gi]         = rdata[gi*8 +: 8];
      assign lane_en[gi]            = !byte_access || (lane == LW'(gi));
      assign wdata_out[gi*8 +: 8]   = byte_access ? wdata[7:0] : wdata[gi*8 +: 8];
   end

   assign rdata_out = byte_access ? {{(DW-8){1'b0}}, lane_bytes[lane]} : rdata;

endmodule

// File: rtl/bus_interface_ws.sv
// Bus interface with wait states: sequences CPU and debug fetch / argument
// read / argument write cycles onto one external memory bus as
// SETUP -> STROBE (READY handshake, minimum wait states, timeout) -> HOLD.
// Ports:
//   CLK, RESETN                      clock, asynchronous active-low reset
//   FETCH/DECODE/EXECUTE/COMMIT      CPU phase strobes (DECODE, COMMIT start cycles)
//   BUS_SEQX                         requested sequence code
//   CPU_ADDR/CPU_DOUT/CPU_BYTEX      CPU request, CPU_DIN registered read data
//   DEBUG_ADDR/DEBUG_DOUT            debug request, DEBUG_DIN registered read data
//   DEBUG_RD/DEBUG_WR                debug completion pulses, DEBUG_DATA_SELX debug active
//   ADDR_BUF/DOUT_BUF/DIN_BUF        external address / write data / read data
//   RD_BUF, WR_BUF, READY_BUF        read strobe, per-lane write strobes, target ready
//   STALL, BUS_ERR                   CPU hold request, timeout abort pulse
module bus_interface_ws
   import bus_interface_ws_pkg::*;
#(
   parameter int AW          = 16,
   parameter int DW          = 16,
   parameter int WAIT_STATES = 0,
   parameter int TIMEOUT     = 64
)(
   input  logic            CLK,
   input  logic            RESETN,
   input  logic            FETCH,
   input  logic            DECODE,
   input  logic            EXECUTE,
   input  logic            COMMIT,
   input  logic [2:0]      BUS_SEQX,
   input  logic [AW-1:0]   CPU_ADDR,
   input  logic [DW-1:0]   CPU_DOUT,
   input  logic            CPU_BYTEX,
   output logic [DW-1:0]   CPU_DIN,
   input  logic [AW-1:0]   DEBUG_ADDR,
   input  logic [DW-1:0]   DEBUG_DOUT,
   output logic [DW-1:0]   DEBUG_DIN,
   output logic            DEBUG_RD,
   output logic            DEBUG_WR,
   output logic            DEBUG_DATA_SELX,
   output logic [AW-1:0]   ADDR_BUF,
   output logic [DW-1:0]   DOUT_BUF,
   input  logic [DW-1:0]   DIN_BUF,
   output logic            RD_BUF,
   output logic [DW/8-1:0] WR_BUF,
   input  logic            READY_BUF,
   output logic            STALL,
   output logic            BUS_ERR
);

   localparam int LANES = DW / 8;
   localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int CW    = $clog2(TIMEOUT + 1);

   bus_state_t      state_reg, state_next;
   logic [AW-1:0]   addr_reg;
   logic [DW-1:0]   wdata_reg;
   logic            byte_reg, write_reg, debug_reg, err_reg;
   logic [CW-1:0]   cnt_reg;
   logic            start_req, complete, abort, ws_met;
   logic [LANES-1:0] lane_en;
   logic [DW-1:0]   wdata_steer, rdata_steer;
   logic            unused_phase;

   // FETCH and EXECUTE are part of the CPU phase bundle but never start a cycle.
   assign unused_phase = &{1'b0, FETCH, EXECUTE};

   assign start_req = (DECODE && seq_is_fetch(BUS_SEQX)) ||
                      (COMMIT && seq_is_arg(BUS_SEQX));

   // With no minimum wait states READY is honoured from the first strobe cycle.
   if (WAIT_STATES == 0) begin : g_ws_none
      assign ws_met = 1'b1;
   end else begin : g_ws_min
      assign ws_met = cnt_reg >= CW'(WAIT_STATES);
   end

   bus_lane_steer #(.DW(DW)) u_steer (
      .byte_access (byte_reg),
      .lane        (addr_reg[LW-1:0]),
      .wdata       (wdata_reg),
      .rdata       (DIN_BUF),
      .lane_en     (lane_en),
      .wdata_out   (wdata_steer),
      .rdata_out   (rdata_steer)
   );

   always_comb begin
      state_next = state_reg;
      complete   = 1'b0;
      abort      = 1'b0;
      case (state_reg)
         BUS_ST_IDLE:   if (start_req) state_next = BUS_ST_SETUP;
         BUS_ST_SETUP:  state_next = BUS_ST_STROBE;
         BUS_ST_STROBE: begin
            // A READY arriving on the last allowed cycle still wins over the abort.
            if (ws_met && READY_BUF) begin
               complete   = 1'b1;
               state_next = BUS_ST_HOLD;
            end else if (cnt_reg == CW'(TIMEOUT - 1)) begin
               abort      = 1'b1;
               state_next = BUS_ST_HOLD;
            end
         end
         BUS_ST_HOLD:   state_next = BUS_ST_IDLE;
         default:       state_next = BUS_ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         state_reg <= BUS_ST_IDLE;
         addr_reg  <= '0;
         wdata_reg <= '0;
         byte_reg  <= 1'b0;
         write_reg <= 1'b0;
         debug_reg <= 1'b0;
         err_reg   <= 1'b0;
         cnt_reg   <= '0;
         CPU_DIN   <= '0;
         DEBUG_DIN <= '0;
      end else begin
         state_reg <= state_next;

         if (state_reg == BUS_ST_IDLE && start_req) begin
            debug_reg <= BUS_SEQX[BUS_SEQX_DEBUG_BIT];
            addr_reg  <= BUS_SEQX[BUS_SEQX_DEBUG_BIT] ? DEBUG_ADDR : CPU_ADDR;
            wdata_reg <= BUS_SEQX[BUS_SEQX_DEBUG_BIT] ? DEBUG_DOUT : CPU_DOUT;
            byte_reg  <= CPU_BYTEX && !seq_is_fetch(BUS_SEQX);
            write_reg <= seq_is_write(BUS_SEQX);
            err_reg   <= 1'b0;
         end

         if (state_reg == BUS_ST_STROBE) cnt_reg <= cnt_reg + 1'b1;
         else                            cnt_reg <= '0;

         if (abort) err_reg <= 1'b1;

         if (complete && !write_reg) begin
            if (debug_reg) DEBUG_DIN <= rdata_steer;
            else           CPU_DIN   <= rdata_steer;
         end
      end
   end

   assign ADDR_BUF        = addr_reg;
   assign DOUT_BUF        = wdata_steer;
   assign RD_BUF          = (state_reg == BUS_ST_STROBE) && !write_reg;
   assign WR_BUF          = (state_reg == BUS_ST_STROBE && write_reg) ? lane_en : '0;
   assign STALL           = (state_reg != BUS_ST_IDLE);
   assign DEBUG_DATA_SELX = (state_reg != BUS_ST_IDLE) && debug_reg;
   assign DEBUG_RD        = (state_reg == BUS_ST_HOLD) && debug_reg && !write_reg && !err_reg;
   assign DEBUG_WR        = (state_reg == BUS_ST_HOLD) && debug_reg && write_reg && !err_reg;
   assign BUS_ERR         = (state_reg == BUS_ST_HOLD) && err_reg;

endmodule

// File: tb/tb_bus_interface_ws.sv
module tb_bus_interface_ws;

   logic clk = 1'b0;
   logic rst_n;
   logic fetch_s, exec_s;
   logic dec0, com0, rdy0, dec1, com1, rdy1;
   logic [2:0]  seq;
   logic [15:0] cpu_addr, cpu_dout, dbg_addr, dbg_dout, din;
   logic        bytex;

   logic [15:0] cpu_din0, dbg_din0, addr0, dout0;
   logic        drd0, dwr0, dsel0, rd0, stall0, err0;
   logic [1:0]  wr0;
   logic [15:0] cpu_din1, dbg_din1, addr1, dout1;
   logic        drd1, dwr1, dsel1, rd1, stall1, err1;
   logic [1:0]  wr1;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   bus_interface_ws #(.AW(16), .DW(16), .WAIT_STATES(0), .TIMEOUT(64)) u0 (
      .CLK(clk), .RESETN(rst_n), .FETCH(fetch_s), .DECODE(dec0), .EXECUTE(exec_s),
      .COMMIT(com0), .BUS_SEQX(seq), .CPU_ADDR(cpu_addr), .CPU_DOUT(cpu_dout),
      .CPU_BYTEX(bytex), .CPU_DIN(cpu_din0), .DEBUG_ADDR(dbg_addr),
      .DEBUG_DOUT(dbg_dout), .DEBUG_DIN(dbg_din0), .DEBUG_RD(drd0), .DEBUG_WR(dwr0),
      .DEBUG_DATA_SELX(dsel0), .ADDR_BUF(addr0), .DOUT_BUF(dout0), .DIN_BUF(din),
      .RD_BUF(rd0), .WR_BUF(wr0), .READY_BUF(rdy0), .STALL(stall0), .BUS_ERR(err0));

   bus_interface_ws #(.AW(16), .DW(16), .WAIT_STATES(2), .TIMEOUT(8)) u1 (
      .CLK(clk), .RESETN(rst_n), .FETCH(fetch_s), .DECODE(dec1), .EXECUTE(exec_s),
      .COMMIT(com1), .BUS_SEQX(seq), .CPU_ADDR(cpu_addr), .CPU_DOUT(cpu_dout),
      .CPU_BYTEX(bytex), .CPU_DIN(cpu_din1), .DEBUG_ADDR(dbg_addr),
      .DEBUG_DOUT(dbg_dout), .DEBUG_DIN(dbg_din1), .DEBUG_RD(drd1), .DEBUG_WR(dwr1),
      .DEBUG_DATA_SELX(dsel1), .ADDR_BUF(addr1), .DOUT_BUF(dout1), .DIN_BUF(din),
      .RD_BUF(rd1), .WR_BUF(wr1), .READY_BUF(rdy1), .STALL(stall1), .BUS_ERR(err1));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
      else passed++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      string       name;
      logic [2:0]  seq;
      logic        commit;
      logic [15:0] cpu_addr, cpu_dout;
      logic        bytex;
      logic [15:0] dbg_addr, dbg_dout, din;
      logic [15:0] e_addr, e_dout;
      logic [1:0]  e_wr;
      logic        e_rd;
      logic [15:0] e_cpu_din, e_dbg_din;
      logic        e_dsel, e_drd, e_dwr;
   } vec_t;

   vec_t vecs [8];

   typedef struct {
      logic       decode, commit;
      logic [2:0] seq;
   } nostart_t;

   nostart_t nost [4];

   initial begin
      int n_rd, n_err;

      //           name       seq  com cpu_addr  cpu_dout  byte dbg_addr  dbg_dout  din       e_addr    e_dout    e_wr   e_rd e_cpu     e_dbg     sel drd dwr
      vecs[0] = '{"ifetch",   3'd1, 0, 16'h1111, 16'h00AB, 1, 16'hDEAD, 16'hDEAD, 16'h3333, 16'h1111, 16'h00AB, 2'b00, 1, 16'h3333, 16'h0000, 0, 0, 0};
      vecs[1] = '{"argwr",    3'd3, 1, 16'h1111, 16'h2222, 0, 16'hDEAD, 16'hDEAD, 16'h3333, 16'h1111, 16'h2222, 2'b11, 0, 16'h3333, 16'h0000, 0, 0, 0};
      vecs[2] = '{"dargwr_b", 3'd7, 1, 16'hC0DE, 16'hC0DE, 1, 16'h5555, 16'h4444, 16'h0000, 16'h5555, 16'h4444, 2'b10, 0, 16'h3333, 16'h0000, 1, 0, 1};
      vecs[3] = '{"dargrd_b", 3'd6, 1, 16'hC0DE, 16'hC0DE, 1, 16'h5554, 16'h0099, 16'hAB12, 16'h5554, 16'h9999, 2'b00, 1, 16'h3333, 16'h0012, 1, 1, 0};
      vecs[4] = '{"argrd_b",  3'd2, 1, 16'h2001, 16'h0000, 1, 16'h5554, 16'hDEAD, 16'hAB12, 16'h2001, 16'h0000, 2'b00, 1, 16'h00AB, 16'h0012, 0, 0, 0};
      vecs[5] = '{"argwr_b",  3'd3, 1, 16'h2000, 16'h1234, 1, 16'hDEAD, 16'hDEAD, 16'hFFFF, 16'h2000, 16'h3434, 2'b01, 0, 16'h00AB, 16'h0012, 0, 0, 0};
      vecs[6] = '{"dfetch",   3'd5, 0, 16'hC0DE, 16'hC0DE, 1, 16'h7777, 16'h5678, 16'hBEEF, 16'h7777, 16'h5678, 2'b00, 1, 16'h00AB, 16'hBEEF, 1, 1, 0};
      vecs[7] = '{"argrd_w",  3'd2, 1, 16'h0003, 16'h0000, 0, 16'hDEAD, 16'hDEAD, 16'h8001, 16'h0003, 16'h0000, 2'b00, 1, 16'h8001, 16'hBEEF, 0, 0, 0};

      nost[0] = '{1'b1, 1'b0, 3'd2};  // ARGRD needs COMMIT
      nost[1] = '{1'b0, 1'b1, 3'd4};  // code 4 is idle
      nost[2] = '{1'b0, 1'b1, 3'd1};  // IFETCH needs DECODE
      nost[3] = '{1'b1, 1'b0, 3'd0};  // idle code

      fetch_s = 0; exec_s = 0;
      dec0 = 0; com0 = 0; rdy0 = 1; dec1 = 0; com1 = 0; rdy1 = 0;
      seq = 0; cpu_addr = 0; cpu_dout = 0; dbg_addr = 0; dbg_dout = 0; din = 0; bytex = 0;
      rst_n = 0;
      tick(); tick();
      rst_n = 1;

      chk("rst_stall",   32'(stall0),   32'h0);
      chk("rst_rd",      32'(rd0),      32'h0);
      chk("rst_wr",      32'(wr0),      32'h0);
      chk("rst_cpu_din", 32'(cpu_din0), 32'h0);
      chk("rst_dbg_din", 32'(dbg_din0), 32'h0);
      chk("rst_addr",    32'(addr0),    32'h0);
      chk("rst_dout",    32'(dout0),    32'h0);
      chk("rst_err",     32'(err0),     32'h0);

      // Table-driven single transactions on the zero-wait-state instance.
      for (int i = 0; i < 8; i++) begin
         seq = vecs[i].seq; cpu_addr = vecs[i].cpu_addr; cpu_dout = vecs[i].cpu_dout;
         bytex = vecs[i].bytex; dbg_addr = vecs[i].dbg_addr; dbg_dout = vecs[i].dbg_dout;
         din = vecs[i].din;
         dec0 = !vecs[i].commit; com0 = vecs[i].commit;
         tick();  // SETUP
         dec0 = 0; com0 = 0;
         chk({vecs[i].name, "_setup_stall"}, 32'(stall0), 32'h1);
         chk({vecs[i].name, "_setup_rd"},    32'(rd0),    32'h0);
         chk({vecs[i].name, "_setup_wr"},    32'(wr0),    32'h0);
         chk({vecs[i].name, "_addr"},        32'(addr0),  32'(vecs[i].e_addr));
         chk({vecs[i].name, "_dout"},        32'(dout0),  32'(vecs[i].e_dout));
         chk({vecs[i].name, "_dsel"},        32'(dsel0),  32'(vecs[i].e_dsel));
         tick();  // STROBE
         chk({vecs[i].name, "_strobe_rd"},   32'(rd0),    32'(vecs[i].e_rd));
         chk({vecs[i].name, "_strobe_wr"},   32'(wr0),    32'(vecs[i].e_wr));
         chk({vecs[i].name, "_strobe_stall"},32'(stall0), 32'h1);
         tick();  // HOLD
         chk({vecs[i].name, "_hold_rd"},     32'(rd0),    32'h0);
         chk({vecs[i].name, "_hold_wr"},     32'(wr0),    32'h0);
         chk({vecs[i].name, "_hold_stall"},  32'(stall0), 32'h1);
         chk({vecs[i].name, "_hold_addr"},   32'(addr0),  32'(vecs[i].e_addr));
         chk({vecs[i].name, "_debug_rd"},    32'(drd0),   32'(vecs[i].e_drd));
         chk({vecs[i].name, "_debug_wr"},    32'(dwr0),   32'(vecs[i].e_dwr));
         chk({vecs[i].name, "_hold_err"},    32'(err0),   32'h0);
         tick();  // IDLE
         chk({vecs[i].name, "_idle_stall"},  32'(stall0), 32'h0);
         chk({vecs[i].name, "_idle_addr"},   32'(addr0),  32'(vecs[i].e_addr));
         chk({vecs[i].name, "_cpu_din"},     32'(cpu_din0), 32'(vecs[i].e_cpu_din));
         chk({vecs[i].name, "_dbg_din"},     32'(dbg_din0), 32'(vecs[i].e_dbg_din));
         $display("txn %0d %s addr=%h cpu_din=%h dbg_din=%h", i, vecs[i].name, addr0, cpu_din0, dbg_din0);
      end

      // Phase/code combinations that must not start a cycle.
      for (int i = 0; i < 4; i++) begin
         seq = nost[i].seq; dec0 = nost[i].decode; com0 = nost[i].commit;
         tick();
         chk($sformatf("nostart_%0d_stall", i), 32'(stall0), 32'h0);
         $display("txn nostart %0d seq=%0d stall=%b", i, nost[i].seq, stall0);
      end
      dec0 = 0; com0 = 0;

      // Wait states: READY low for 5 strobe cycles, high from the 6th.
      seq = 3'd2; cpu_addr = 16'h0100; bytex = 0; din = 16'h5A5A; rdy1 = 1; com1 = 1;
      tick();  // SETUP with READY high
      com1 = 0; rdy1 = 0;
      chk("ws_setup_rd", 32'(rd1), 32'h0);
      n_rd = 0; n_err = 0;
      for (int c = 0; c < 30 && stall1; c++) begin
         tick();
         if (rd1) begin
            n_rd++;
            if (n_rd == 6) rdy1 = 1;
         end
         if (err1) n_err++;
      end
      chk("ws_done",    32'(stall1),   32'h0);
      chk("ws_rd_len",  32'(n_rd),     32'd6);
      chk("ws_no_err",  32'(n_err),    32'd0);
      chk("ws_cpu_din", 32'(cpu_din1), 32'h5A5A);
      $display("txn wait_states rd_cycles=%0d cpu_din=%h", n_rd, cpu_din1);

      // Minimum wait states: READY high throughout, including SETUP.
      din = 16'h1357; com1 = 1; rdy1 = 1;
      tick();
      com1 = 0;
      n_rd = 0;
      for (int c = 0; c < 30 && stall1; c++) begin
         tick();
         if (rd1) n_rd++;
      end
      chk("ws_min_done",    32'(stall1),   32'h0);
      chk("ws_min_rd_len",  32'(n_rd),     32'd3);
      chk("ws_min_cpu_din", 32'(cpu_din1), 32'h1357);
      $display("txn min_wait rd_cycles=%0d cpu_din=%h", n_rd, cpu_din1);

      // Timeout: READY never asserted.
      din = 16'hFFFF; rdy1 = 0; com1 = 1;
      tick();
      com1 = 0;
      n_rd = 0; n_err = 0;
      for (int c = 0; c < 40 && stall1; c++) begin
         tick();
         if (rd1) n_rd++;
         if (err1) begin
            n_err++;
            chk("to_err_no_rd", 32'(rd1), 32'h0);
         end
      end
      chk("to_done",    32'(stall1),   32'h0);
      chk("to_rd_len",  32'(n_rd),     32'd8);
      chk("to_err_cnt", 32'(n_err),    32'd1);
      chk("to_cpu_din", 32'(cpu_din1), 32'h1357);
      tick();
      chk("to_err_gone", 32'(err1), 32'h0);
      $display("txn timeout rd_cycles=%0d err_pulses=%0d cpu_din=%h", n_rd, n_err, cpu_din1);

      // Asynchronous reset in the middle of a strobe.
      com1 = 1;
      tick();  // SETUP
      com1 = 0;
      tick(); tick();  // STROBE, second strobe cycle
      chk("arst_pre_rd",    32'(rd1),    32'h1);
      chk("arst_pre_stall", 32'(stall1), 32'h1);
      #2 rst_n = 0;
      #1;
      chk("arst_rd",      32'(rd1),      32'h0);
      chk("arst_stall",   32'(stall1),   32'h0);
      chk("arst_cpu_din", 32'(cpu_din1), 32'h0);
      chk("arst_addr",    32'(addr1),    32'h0);
      $display("txn async_reset rd=%b stall=%b", rd1, stall1);
      tick();
      rst_n = 1;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
